// File: rtl/melody_scheduler.sv
// -----------------------------------------------------------------------------
// melody_scheduler
//   Note sequencer and fixed-priority arbiter for the speaker datapath. Three
//   sources share a single note-divider pair: looping background music (BGM),
//   a win jingle and a lose jingle. Priority is LOSE > WIN > BGM. Each source
//   steps through its own note table, and each note lasts a given number of
//   beats.
//
//   Optional feature macro: MELODY_GAP_EN
//     When it is defined, both dividers are silenced for the last GAP_CYCLES
//     cycles of each note's final beat, so that repeated notes sound separate.
//     When it is undefined, notes play legato.
//
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   req_bgm        in   level; BGM plays while high
//   req_win        in   one-cycle pulse; request the win jingle
//   req_lose       in   one-cycle pulse; request the lose jingle
//   mute           in   level; silences the outputs one cycle later while
//                       sequencing continues
//   note_div_right out  [21:0] divider for the right buzzer; 0 = silence
//   note_div_left  out  [21:0] right divider shifted left by one (one octave
//                       down)
//   active_src     out  [1:0]  0 idle, 1 BGM, 2 win, 3 lose
//   jingle_done    out  one-cycle pulse when a jingle finishes naturally
// -----------------------------------------------------------------------------
module melody_scheduler #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BEAT_DIV   = 25_000_000,
  parameter int GAP_CYCLES = 2_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_bgm,
  input  logic        req_win,
  input  logic        req_lose,
  input  logic        mute,
  output logic [21:0] note_div_right,
  output logic [21:0] note_div_left,
  output logic [1:0]  active_src,
  output logic        jingle_done
);

  localparam int TICK_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BEAT_DIV - 1);
  localparam logic [TICK_W-1:0] GAP_START = TICK_W'(BEAT_DIV - GAP_CYCLES);

`ifdef MELODY_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  // Note dividers are CLK_HZ / f, truncated.
  localparam logic [21:0] DIV_C4 = 22'(CLK_HZ / 262);
  localparam logic [21:0] DIV_D4 = 22'(CLK_HZ / 294);
  localparam logic [21:0] DIV_E4 = 22'(CLK_HZ / 330);
  localparam logic [21:0] DIV_F4 = 22'(CLK_HZ / 349);
  localparam logic [21:0] DIV_G4 = 22'(CLK_HZ / 392);
  localparam logic [21:0] DIV_A4 = 22'(CLK_HZ / 440);
  localparam logic [21:0] DIV_B4 = 22'(CLK_HZ / 494);
  localparam logic [21:0] DIV_C5 = 22'(CLK_HZ / 523);

  // The encoding equals the active_src code.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BGM  = 2'd1,
    S_WIN  = 2'd2,
    S_LOSE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [2:0]          beat_q, beat_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                mute_q;
  logic                done_q, done_d;

  logic [3:0]          note_code;
  logic [2:0]          note_dur;
  logic [21:0]         code_div;
  logic                beat_end, last_beat, gap_active;
  logic [2:0]          adv_idx, adv_beat;
  logic [TICK_W-1:0]   adv_tick;

  // Note tables: the code and duration of the current note.
  always_comb begin
    // NOTE: every signal driven in always_comb gets a default first; a path
    // that leaves a signal unassigned would infer a latch.
    note_code = 4'd0;
    note_dur  = 3'd1;
    unique case (state_q)
      S_BGM: begin
        unique case (idx_q)
          3'd0:    note_code = 4'd1;
          3'd1:    note_code = 4'd3;
          3'd2:    note_code = 4'd5;
          3'd3:    note_code = 4'd3;
          3'd4:    note_code = 4'd4;
          3'd5:    note_code = 4'd2;
          3'd6:    note_code = 4'd7;
          default: note_code = 4'd0;
        endcase
      end
      S_WIN: begin
        unique case (idx_q[1:0])
          2'd0:    note_code = 4'd5;
          2'd1:    note_code = 4'd6;
          2'd2:    note_code = 4'd7;
          default: note_code = 4'd8;
        endcase
        note_dur = (idx_q[1:0] == 2'd3) ? 3'd3 : 3'd1;
      end
      S_LOSE: begin
        unique case (idx_q[1:0])
          2'd0:    note_code = 4'd5;
          2'd1:    note_code = 4'd4;
          2'd2:    note_code = 4'd3;
          default: note_code = 4'd1;
        endcase
        note_dur = (idx_q[1:0] == 2'd3) ? 3'd4 : 3'd2;
      end
      default: begin
        note_code = 4'd0;
        note_dur  = 3'd1;
      end
    endcase
  end

  always_comb begin
    code_div = '0;
    unique case (note_code)
      4'd1:    code_div = DIV_C4;
      4'd2:    code_div = DIV_D4;
      4'd3:    code_div = DIV_E4;
      4'd4:    code_div = DIV_F4;
      4'd5:    code_div = DIV_G4;
      4'd6:    code_div = DIV_A4;
      4'd7:    code_div = DIV_B4;
      4'd8:    code_div = DIV_C5;
      default: code_div = '0;
    endcase
  end

  assign beat_end   = (tick_q == TICK_LAST);
  assign last_beat  = (beat_q == 3'(note_dur - 3'd1));
  assign gap_active = GAP_EN && last_beat && (tick_q >= GAP_START);

  // Normal progression within a song. The 3-bit idx wraps 7->0 on its own,
  // which provides the BGM loop.
  always_comb begin
    adv_idx  = idx_q;
    adv_beat = beat_q;
    adv_tick = tick_q + TICK_W'(1);
    if (beat_end) begin
      adv_tick = '0;
      if (last_beat) begin
        adv_beat = '0;
        adv_idx  = idx_q + 3'd1;
      end else begin
        adv_beat = beat_q + 3'd1;
      end
    end
  end

  // Arbitration and next state. Every song start and every return to IDLE
  // clears the position, so each song begins with a full-length first note.
  always_comb begin
    state_d = state_q;
    idx_d   = adv_idx;
    beat_d  = adv_beat;
    tick_d  = adv_tick;
    done_d  = 1'b0;
    if (req_lose) begin
      state_d = S_LOSE;
      idx_d   = '0;
      beat_d  = '0;
      tick_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          idx_d  = '0;
          beat_d = '0;
          tick_d = '0;
          if (req_win)      state_d = S_WIN;
          else if (req_bgm) state_d = S_BGM;
        end
        S_BGM: begin
          if (req_win || !req_bgm) begin
            state_d = req_win ? S_WIN : S_IDLE;
            idx_d   = '0;
            beat_d  = '0;
            tick_d  = '0;
          end
        end
        default: begin
          // Both jingles have four notes; the end of note 3 finishes the jingle.
          if (beat_end && last_beat && (idx_q[1:0] == 2'd3)) begin
            done_d  = 1'b1;
            state_d = req_bgm ? S_BGM : S_IDLE;
            idx_d   = '0;
            beat_d  = '0;
            tick_d  = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      beat_q  <= '0;
      tick_q  <= '0;
      mute_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // register samples the pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      tick_q  <= tick_d;
      mute_q  <= mute;
      done_q  <= done_d;
    end
  end

  // The outputs decode registered state only; a request never reaches them
  // combinationally.
  assign note_div_right = (state_q != S_IDLE && !mute_q && !gap_active) ? code_div : '0;
  assign note_div_left  = {note_div_right[20:0], 1'b0};
  assign active_src     = state_q;
  assign jingle_done    = done_q;

endmodule

// File: tb/tb_melody_scheduler.sv
// -----------------------------------------------------------------------------
// tb_melody_scheduler
//   Directed, table-driven bench for melody_scheduler with BEAT_DIV=4 and
//   GAP_CYCLES=1. Each table row holds the inputs for a number of cycles,
//   with the request pulses applied on the first cycle only, and then checks
//   the outputs. Hand-written sequences cover asynchronous reset and a win
//   jingle pre-empted by the lose jingle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_melody_scheduler;

`ifdef MELODY_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_bgm, req_win, req_lose, mute;
  logic [21:0] note_div_right, note_div_left;
  logic [1:0]  active_src;
  logic        jingle_done;

  int total = 0;
  int bad   = 0;

  melody_scheduler #(
    .BEAT_DIV   (4),
    .GAP_CYCLES (1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_bgm        (req_bgm),
    .req_win        (req_win),
    .req_lose       (req_lose),
    .mute           (mute),
    .note_div_right (note_div_right),
    .note_div_left  (note_div_left),
    .active_src     (active_src),
    .jingle_done    (jingle_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       bgm;
    logic       win;
    logic       lose;
    logic       mte;
    int         cycles;
    logic [1:0] src;
    int         right;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic b, logic w, logic l, logic m,
                              int c, logic [1:0] s, int r, logic d);
    vec_t v;
    v.name = n; v.bgm = b; v.win = w; v.lose = l; v.mte = m;
    v.cycles = c; v.src = s; v.right = r; v.done = d;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [1:0] src, input int right,
                            input logic done);
    check({name, ".src"},   32'(active_src),     32'(src));
    check({name, ".right"}, 32'(note_div_right), 32'(right));
    check({name, ".left"},  32'(note_div_left),  32'(right * 2));
    check({name, ".done"},  32'(jingle_done),    32'(done));
  endtask

  // Called at a negedge; it advances one clock and returns at the next negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    req_win  = 1'b0;
    req_lose = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_bgm = 1'b0; req_win = 1'b0; req_lose = 1'b0; mute = 1'b0;

    // BGM sequence and wrap.
    vecs.push_back(mk("bgm_c4",     1,0,0,0,  1, 2'd1, 381679, 0));
    vecs.push_back(mk("bgm_e4",     1,0,0,0,  4, 2'd1, 303030, 0));
    vecs.push_back(mk("bgm_g4",     1,0,0,0,  4, 2'd1, 255102, 0));
    vecs.push_back(mk("bgm_b4",     1,0,0,0, 16, 2'd1, 202429, 0));
    vecs.push_back(mk("bgm_rest",   1,0,0,0,  4, 2'd1, 0,      0));
    vecs.push_back(mk("bgm_wrap",   1,0,0,0,  4, 2'd1, 381679, 0));
    // Win pre-empts BGM, finishes, and BGM restarts from idx 0.
    vecs.push_back(mk("win_g4",     1,1,0,0,  1, 2'd2, 255102, 0));
    vecs.push_back(mk("win_a4",     1,0,0,0,  4, 2'd2, 227272, 0));
    vecs.push_back(mk("win_b4",     1,0,0,0,  4, 2'd2, 202429, 0));
    vecs.push_back(mk("win_c5",     1,0,0,0,  4, 2'd2, 191204, 0));
    vecs.push_back(mk("win_c5_end", 1,0,0,0, 11, 2'd2, GAP_ON ? 0 : 191204, 0));
    vecs.push_back(mk("win_done",   1,0,0,0,  1, 2'd1, 381679, 1));
    vecs.push_back(mk("bgm_after",  1,0,0,0,  1, 2'd1, 381679, 0));
    // Mute silences the output one cycle later; the position keeps moving.
    vecs.push_back(mk("mute_on",    1,0,0,1,  1, 2'd1, 0,      0));
    vecs.push_back(mk("mute_hold",  1,0,0,1,  6, 2'd1, 0,      0));
    vecs.push_back(mk("mute_off",   1,0,0,0,  1, 2'd1, 255102, 0));
    vecs.push_back(mk("bgm_off",    0,0,0,0,  1, 2'd0, 0,      0));
    // Simultaneous win and lose: lose plays, and no win follows.
    vecs.push_back(mk("winlose",    0,1,1,0,  1, 2'd3, 255102, 0));
    vecs.push_back(mk("lose_g4_end",0,0,0,0,  7, 2'd3, GAP_ON ? 0 : 255102, 0));
    vecs.push_back(mk("lose_f4",    0,0,0,0,  1, 2'd3, 286532, 0));
    vecs.push_back(mk("lose_e4",    0,0,0,0,  8, 2'd3, 303030, 0));
    vecs.push_back(mk("lose_c4",    0,0,0,0,  8, 2'd3, 381679, 0));
    vecs.push_back(mk("lose_c4_end",0,0,0,0, 15, 2'd3, GAP_ON ? 0 : 381679, 0));
    vecs.push_back(mk("lose_done",  0,0,0,0,  1, 2'd0, 0,      1));
    vecs.push_back(mk("idle_after", 0,0,0,0,  1, 2'd0, 0,      0));
    // A lose request restarts LOSE; a win request during LOSE is ignored.
    vecs.push_back(mk("lose_start", 0,0,1,0,  1, 2'd3, 255102, 0));
    vecs.push_back(mk("lose_mid",   0,0,0,0,  9, 2'd3, 286532, 0));
    vecs.push_back(mk("lose_again", 0,0,1,0,  1, 2'd3, 255102, 0));
    vecs.push_back(mk("win_ignored",0,1,0,0,  1, 2'd3, 255102, 0));

    // Reset state.
    repeat (3) @(negedge clk);
    check_outs("reset", 2'd0, 0, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      req_bgm  = vecs[i].bgm;
      mute     = vecs[i].mte;
      req_win  = vecs[i].win;
      req_lose = vecs[i].lose;
      for (int c = 0; c < vecs[i].cycles; c++) tick();
      check_outs(vecs[i].name, vecs[i].src, vecs[i].right, vecs[i].done);
    end

    // Asynchronous reset mid-jingle clears the outputs without a clock edge.
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 2'd0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // A win jingle at idx 2 is pre-empted by lose; only lose reports done.
    req_bgm = 1'b0;
    req_win = 1'b1;
    tick();
    check_outs("pre_win", 2'd2, 255102, 1'b0);
    for (int c = 0; c < 8; c++) tick();
    check_outs("pre_win_b4", 2'd2, 202429, 1'b0);
    req_lose = 1'b1;
    tick();
    check_outs("pre_lose", 2'd3, 255102, 1'b0);
    for (int c = 1; c < 40; c++) begin
      tick();
      check("pre_lose_nodone", 32'(jingle_done), 32'd0);
      check("pre_lose_src", 32'(active_src), 32'd3);
    end
    tick();
    check_outs("pre_lose_done", 2'd0, 0, 1'b1);

`ifdef MELODY_GAP_EN
    // The last tick of each one-beat BGM note is silent.
    req_bgm = 1'b1;
    tick();
    check_outs("gap_c4", 2'd1, 381679, 1'b0);
    for (int c = 0; c < 3; c++) tick();
    check_outs("gap_silent", 2'd1, 0, 1'b0);
    tick();
    check_outs("gap_e4", 2'd1, 303030, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
